bit_unstuff_param: RTL

Parametrised USB Rx bit-unstuff controller for the decoded (post-NRZI) serial stream.
- Counts consecutive bits of a configurable polarity at each bit-sample strobe.
- After RUN_LEN such bits, it flags the next sampled bit as a stuffed bit so the Rx shift register skips it.
- Checks the stuffed bit's value and raises a sticky stuff-error flag on violation.
- Sits between the NRZI decoder / edge detector and the Rx shift register; the Rx controller consumes stuff_err and drives clear at SYNC/EOP.

---
 rtl/usb_rx_pkg.sv | 18 +
 rtl/run_length_counter.sv | 37 +++
 rtl/bit_unstuff_param.sv | 105 ++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
package usb_rx_pkg;

    // Bit-unstuff FSM: HUNT counts a run, STUFF waits for the stuffed bit.
    typedef enum logic {
        HUNT  = 1'b0,
        STUFF = 1'b1
    } unstuff_state_t;

    // Run length after which USB inserts a stuffed zero.
    localparam int USB_STUFF_RUN = 6;

    // True when a sampled bit belongs to the counted run polarity.
    function automatic logic is_run_bit(input logic bit_val, input logic pol);
        return (bit_val == pol);
    endfunction

endpackage

// File: rtl/run_length_counter.sv
// Saturating run-length counter with a sync clear and a terminal-hit pulse.
// term_hit is high in the cycle whose count_enable makes the count reach TERM,
// so the owner can react on the same edge the counter reaches its top value.
module run_length_counter #(
    parameter int CNT_W = 3,
    parameter int TERM  = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    output logic [CNT_W-1:0] count_out,
    output logic             term_hit
);

    localparam logic [CNT_W-1:0] TERM_V    = CNT_W'(TERM);
    localparam logic [CNT_W-1:0] TERM_M1_V = CNT_W'(TERM - 1);

    logic [CNT_W-1:0] count_r;

    // Count enabled bits, clear has priority, never move past TERM.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_enable && (count_r != TERM_V)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count_out = count_r;
    assign term_hit  = count_enable & ~clear & (count_r == TERM_M1_V);

endmodule

// File: rtl/bit_unstuff_param.sv
// USB Rx bit-unstuff controller: counts runs of RUN_POL bits on each sample
// strobe, marks the bit following RUN_LEN of them as stuffed and checks it.
module bit_unstuff_param
    import usb_rx_pkg::*;
#(
    parameter int   RUN_LEN = USB_STUFF_RUN,
    parameter logic RUN_POL = 1'b1,
    parameter int   CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             d_orig,
    input  logic             shift_enable,
    output logic             shift_stop,
    output logic             stuff_err,
    output logic [CNT_W-1:0] run_count
);

    unstuff_state_t state_r;
    logic           shift_stop_r;
    logic           stuff_err_r;
    logic           run_bit_s;
    logic           cnt_clear_s;
    logic           cnt_en_s;
    logic           term_hit_s;

    // Counter control: the counter only runs in HUNT and restarts on any
    // break of the run, on bypass/clear, and while a stuffed bit is pending.
    always_comb begin
        run_bit_s   = is_run_bit(d_orig, RUN_POL);
        cnt_clear_s = 1'b0;
        cnt_en_s    = 1'b0;
        if (clear || !enable || (state_r == STUFF)) begin
            cnt_clear_s = 1'b1;
        end else if (shift_enable && !run_bit_s) begin
            cnt_clear_s = 1'b1;
        end else begin
            cnt_en_s = shift_enable;
        end
    end

    run_length_counter #(
        .CNT_W (CNT_W),
        .TERM  (RUN_LEN)
    ) u_run_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear_s),
        .count_enable (cnt_en_s),
        .count_out    (run_count),
        .term_hit     (term_hit_s)
    );

    // FSM with registered shift_stop and sticky stuff_err.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= HUNT;
            shift_stop_r <= 1'b0;
            stuff_err_r  <= 1'b0;
        end else if (clear) begin
            state_r      <= HUNT;
            shift_stop_r <= 1'b0;
            stuff_err_r  <= 1'b0;
        end else if (!enable) begin
            state_r      <= HUNT;
            shift_stop_r <= 1'b0;
            stuff_err_r  <= stuff_err_r;
        end else begin
            case (state_r)
                HUNT: begin
                    if (term_hit_s) begin
                        state_r      <= STUFF;
                        shift_stop_r <= 1'b1;
                    end else begin
                        state_r      <= HUNT;
                        shift_stop_r <= 1'b0;
                    end
                    stuff_err_r <= stuff_err_r;
                end
                STUFF: begin
                    if (shift_enable) begin
                        state_r      <= HUNT;
                        shift_stop_r <= 1'b0;
                        stuff_err_r  <= stuff_err_r | run_bit_s;
                    end else begin
                        state_r      <= STUFF;
                        shift_stop_r <= 1'b1;
                        stuff_err_r  <= stuff_err_r;
                    end
                end
                default: begin
                    state_r      <= HUNT;
                    shift_stop_r <= 1'b0;
                    stuff_err_r  <= stuff_err_r;
                end
            endcase
        end
    end

    assign shift_stop = shift_stop_r;
    assign stuff_err  = stuff_err_r;

endmodule
